// File: rtl/sram_data_port.sv
// MEM-stage data port: runs byte/halfword/word loads and stores against a 16-bit async SRAM
// as one or two halfword phases and returns formatted load data with a one-cycle ready pulse.
module sram_data_port #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned WIDTH         = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] mem_in,
    input  logic [2:0]       MemLen,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [WIDTH-1:0] mem_out,
    output logic             ready,
    output logic             err,
    output logic             busy,
    output logic [19:0]      sram_addr,
    output logic [15:0]      sram_dq_out,
    input  logic [15:0]      sram_dq_in,
    output logic             sram_dq_oe,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic             sram_ub_n,
    output logic             sram_lb_n
);

    localparam int unsigned CntW = $clog2(ACCESS_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [20:0]       addr_q, addr_d;
    logic [2:0]        len_q, len_d;
    logic              wr_q, wr_d;
    logic [31:0]       data_q, data_d;
    logic [15:0]       lo_q, lo_d;
    logic              reject;

    logic [WIDTH-1:0]  mem_out_q, mem_out_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [19:0]       sram_addr_q, sram_addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;

    logic              len_ok_rd, len_ok_wr, misaligned, bad_req, phase_last;
    logic [7:0]        byte_sel;
    logic [WIDTH-1:0]  load_fmt;

    always_comb begin
        len_ok_rd  = MemLen inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        len_ok_wr  = MemLen inside {3'b000, 3'b001, 3'b010};
        misaligned = ((MemLen[1:0] == 2'b01) && addr[0]) ||
                     ((MemLen[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        bad_req    = (MemRead && MemWrite) || (MemWrite ? !len_ok_wr : !len_ok_rd) || misaligned;
        phase_last = (cnt_q == CntLast);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wr_d    = wr_q;
        data_d  = data_q;
        lo_d    = lo_q;
        reject  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MemRead || MemWrite) begin
                    if (bad_req) begin
                        state_d = StDone;
                        reject  = 1'b1;
                    end else begin
                        state_d = StLo;
                        cnt_d   = '0;
                        addr_d  = addr[20:0];
                        len_d   = MemLen;
                        wr_d    = MemWrite;
                        data_d  = mem_in[31:0];
                    end
                end
            end
            StLo: begin
                if (phase_last) begin
                    lo_d    = sram_dq_in;
                    cnt_d   = '0;
                    state_d = (len_q[1:0] == 2'b10) ? StHi : StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHi: begin
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sram_addr_d = '0;
        dq_out_d    = '0;
        ready_d     = (state_d == StDone);
        err_d       = reject;
        busy_d      = (state_d != StIdle);

        byte_sel = addr_q[0] ? sram_dq_in[15:8] : sram_dq_in[7:0];
        load_fmt = '0;
        case (len_q)
            3'b000:  load_fmt = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {{(WIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_fmt = {{(WIDTH-16){sram_dq_in[15]}}, sram_dq_in};
            3'b101:  load_fmt = {{(WIDTH-16){1'b0}}, sram_dq_in};
            default: load_fmt[31:0] = {sram_dq_in, lo_q};
        endcase

        mem_out_d = mem_out_q;
        if (reject && MemRead) begin
            mem_out_d = '0;
        end else if (state_d == StDone && state_q != StIdle && !wr_q) begin
            mem_out_d = load_fmt;
        end

        if (state_d == StLo || state_d == StHi) begin
            ce_n_d      = 1'b0;
            ub_n_d      = 1'b0;
            lb_n_d      = 1'b0;
            sram_addr_d = (state_d == StHi) ? addr_d[20:1] + 20'd1 : addr_d[20:1];
            if (wr_d) begin
                dq_oe_d = 1'b1;
                // Release we_n on the last cycle so data and address stay valid past the edge.
                we_n_d  = (cnt_d == CntLast);
                case (len_d[1:0])
                    2'b00: begin
                        dq_out_d = {data_d[7:0], data_d[7:0]};
                        ub_n_d   = ~addr_d[0];
                        lb_n_d   = addr_d[0];
                    end
                    2'b01:   dq_out_d = data_d[15:0];
                    default: dq_out_d = (state_d == StHi) ? data_d[31:16] : data_d[15:0];
                endcase
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_out_q   <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
        end else begin
            mem_out_q   <= mem_out_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
        end
    end

    assign mem_out     = mem_out_q;
    assign ready       = ready_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_sram_data_port.sv
// Directed bench for sram_data_port with a small behavioural SRAM on the halfword bus.
module tb_sram_data_port;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] addr, mem_in;
    logic [2:0]  MemLen;
    logic        MemRead, MemWrite;
    logic [31:0] mem_out;
    logic        ready, err, busy;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_data_port #(.ACCESS_CYCLES(2), .WIDTH(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .addr       (addr),
        .mem_in     (mem_in),
        .MemLen     (MemLen),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_out    (mem_out),
        .ready      (ready),
        .err        (err),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // SRAM model: 256 halfwords, byte-lane writes while we_n is low.
    bit [15:0] mem [0:255];
    always @(posedge CLK) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
        end
    end
    assign sram_dq_in = sram_oe_n ? 16'hdead : mem[sram_addr[7:0]];

    // Per-cycle log of one access; strobe vector is {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}.
    logic [19:0] lg_addr [$];
    logic [15:0] lg_dq   [$];
    logic [5:0]  lg_str  [$];
    int          lat;
    logic        err_seen;
    int          active;

    function automatic logic [5:0] strobes();
        return {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe};
    endfunction

    // Drives one request from IDLE until ready (bounded), then returns with the DUT idle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] len,
                              input logic [31:0] a, input logic [31:0] d);
        lg_addr.delete();
        lg_dq.delete();
        lg_str.delete();
        lat      = -1;
        err_seen = 1'b0;
        active   = 0;
        MemRead  = rd;
        MemWrite = wr;
        MemLen   = len;
        addr     = a;
        mem_in   = d;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            lg_addr.push_back(sram_addr);
            lg_dq.push_back(sram_dq_out);
            lg_str.push_back(strobes());
            if (strobes() != 6'b111110) active++;
            if (ready) begin
                lat      = c;
                err_seen = err;
                break;
            end
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemLen = 3'b000; addr = '0; mem_in = '0;
        repeat (2) @(posedge CLK);
        #1;
        vectors++; if (strobes() !== 6'b111110) begin miscompares++;
            $display("FAIL reset_strobes got %b want 111110", strobes()); end
        vectors++; if ({ready, err, busy} !== 3'b000) begin miscompares++;
            $display("FAIL reset_flags got %b want 000", {ready, err, busy}); end
        vectors++; if (mem_out !== 32'h0) begin miscompares++;
            $display("FAIL reset_mem_out got %h want 00000000", mem_out); end
        vectors++; if ({sram_addr, sram_dq_out} !== 36'h0) begin miscompares++;
            $display("FAIL reset_bus got %h/%h want 0/0", sram_addr, sram_dq_out); end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_sw_lw();
        run_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678);
        vectors++; if (lat !== 5 || err_seen !== 1'b0) begin miscompares++;
            $display("FAIL sw_ready got lat=%0d err=%b want lat=5 err=0", lat, err_seen); end
        vectors++; if (lg_addr[0] !== 20'h20 || lg_dq[0] !== 16'h5678 || lg_str[0] !== 6'b010001)
            begin miscompares++; $display("FAIL sw_lo_phase got %h/%h/%b want 20/5678/010001",
                                          lg_addr[0], lg_dq[0], lg_str[0]); end
        vectors++; if (lg_addr[1] !== 20'h20 || lg_str[1] !== 6'b011001) begin miscompares++;
            $display("FAIL sw_lo_hold got %h/%b want 20/011001", lg_addr[1], lg_str[1]); end
        vectors++; if (lg_addr[2] !== 20'h21 || lg_dq[2] !== 16'h1234 || lg_str[2] !== 6'b010001)
            begin miscompares++; $display("FAIL sw_hi_phase got %h/%h/%b want 21/1234/010001",
                                          lg_addr[2], lg_dq[2], lg_str[2]); end
        vectors++; if (lg_str[3] !== 6'b011001) begin miscompares++;
            $display("FAIL sw_hi_hold got %b want 011001", lg_str[3]); end
        vectors++; if (mem_out !== 32'h0) begin miscompares++;
            $display("FAIL sw_mem_out_kept got %h want 00000000", mem_out); end
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        vectors++; if (lat !== 5 || mem_out !== 32'h12345678) begin miscompares++;
            $display("FAIL lw_data got lat=%0d %h want lat=5 12345678", lat, mem_out); end
        vectors++; if (lg_str[0] !== 6'b001000 || lg_addr[0] !== 20'h20) begin miscompares++;
            $display("FAIL lw_read_strobes got %b/%h want 001000/20", lg_str[0], lg_addr[0]); end
    endtask

    task automatic test_reset_mid();
        int rdy_cnt;
        MemRead = 1'b1; MemWrite = 1'b0; MemLen = 3'b010; addr = 32'h40;
        repeat (3) begin @(posedge CLK); #1; end
        vectors++; if (busy !== 1'b1 || sram_addr !== 20'h21) begin miscompares++;
            $display("FAIL rst_mid_in_hi got busy=%b addr=%h want 1/21", busy, sram_addr); end
        RST = 1'b1;
        @(posedge CLK); #1;
        vectors++; if (strobes() !== 6'b111110 || busy !== 1'b0 || ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_idle got %b busy=%b ready=%b want 111110/0/0",
                                    strobes(), busy, ready); end
        vectors++; if (mem_out !== 32'h0) begin miscompares++;
            $display("FAIL rst_mid_mem_out got %h want 00000000", mem_out); end
        RST = 1'b0; MemRead = 1'b0;
        rdy_cnt = 0;
        repeat (4) begin @(posedge CLK); #1; if (ready) rdy_cnt++; end
        vectors++; if (rdy_cnt !== 0) begin miscompares++;
            $display("FAIL rst_mid_no_ready got %0d pulses want 0", rdy_cnt); end
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        vectors++; if (lat !== 5 || mem_out !== 32'h12345678) begin miscompares++;
            $display("FAIL rst_mid_fresh_lw got lat=%0d %h want 5 12345678", lat, mem_out); end
    endtask

    task automatic test_back_to_back();
        int rdy [$];
        int bad_data;
        bad_data = 0;
        MemRead = 1'b1; MemWrite = 1'b0; MemLen = 3'b010; addr = 32'h40;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1;
            if (ready) begin
                rdy.push_back(c);
                if (mem_out !== 32'h12345678) bad_data++;
            end
        end
        MemRead = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #1;
            if (!busy) break;
        end
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL b2b_drain got busy=%b want 0", busy); end
        vectors++; if (rdy.size() !== 3 || bad_data !== 0) begin miscompares++;
            $display("FAIL b2b_count got %0d pulses %0d bad want 3 0", rdy.size(), bad_data); end
        vectors++; if (rdy[0] !== 5 || rdy[1] - rdy[0] !== 6 || rdy[2] - rdy[1] !== 6) begin
            miscompares++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 5,11,17",
                                    rdy[0], rdy[1], rdy[2]); end
    endtask

    task automatic test_byte();
        run_access(1'b0, 1'b1, 3'b000, 32'h43, 32'h00000080);
        vectors++; if (lat !== 3) begin miscompares++;
            $display("FAIL sb_ready got lat=%0d want 3", lat); end
        vectors++; if (lg_addr[0] !== 20'h21 || lg_dq[0] !== 16'h8080 || lg_str[0] !== 6'b010011)
            begin miscompares++; $display("FAIL sb_lanes got %h/%h/%b want 21/8080/010011",
                                          lg_addr[0], lg_dq[0], lg_str[0]); end
        run_access(1'b1, 1'b0, 3'b000, 32'h43, 32'h0);
        vectors++; if (lat !== 3 || mem_out !== 32'hffffff80) begin miscompares++;
            $display("FAIL lb_upper got lat=%0d %h want 3 ffffff80", lat, mem_out); end
        run_access(1'b1, 1'b0, 3'b100, 32'h43, 32'h0);
        vectors++; if (mem_out !== 32'h00000080) begin miscompares++;
            $display("FAIL lbu_upper got %h want 00000080", mem_out); end
        // The low byte of halfword 0x21 still holds 0x34 from the earlier word store.
        run_access(1'b1, 1'b0, 3'b000, 32'h42, 32'h0);
        vectors++; if (mem_out !== 32'h00000034) begin miscompares++;
            $display("FAIL lb_lower got %h want 00000034", mem_out); end
    endtask

    task automatic test_half();
        run_access(1'b0, 1'b1, 3'b001, 32'h10, 32'habcd8001);
        vectors++; if (lat !== 3 || lg_dq[0] !== 16'h8001 || lg_str[0] !== 6'b010001) begin
            miscompares++; $display("FAIL sh_phase got lat=%0d %h/%b want 3 8001/010001",
                                    lat, lg_dq[0], lg_str[0]); end
        run_access(1'b1, 1'b0, 3'b001, 32'h10, 32'h0);
        vectors++; if (lat !== 3 || mem_out !== 32'hffff8001) begin miscompares++;
            $display("FAIL lh_sext got lat=%0d %h want 3 ffff8001", lat, mem_out); end
        run_access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
        vectors++; if (mem_out !== 32'h00008001) begin miscompares++;
            $display("FAIL lhu_zext got %h want 00008001", mem_out); end
    endtask

    task automatic test_reject();
        run_access(1'b1, 1'b0, 3'b010, 32'h42, 32'h0);
        vectors++; if (lat !== 1 || err_seen !== 1'b1 || active !== 0) begin miscompares++;
            $display("FAIL rej_lw_misaligned got lat=%0d err=%b act=%0d want 1/1/0",
                     lat, err_seen, active); end
        vectors++; if (mem_out !== 32'h0) begin miscompares++;
            $display("FAIL rej_lw_mem_out got %h want 00000000", mem_out); end
        run_access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
        run_access(1'b0, 1'b1, 3'b001, 32'h41, 32'h5555);
        vectors++; if (lat !== 1 || err_seen !== 1'b1 || active !== 0) begin miscompares++;
            $display("FAIL rej_sh_misaligned got lat=%0d err=%b act=%0d want 1/1/0",
                     lat, err_seen, active); end
        vectors++; if (mem_out !== 32'h00008001 || mem[8'h20] !== 16'h5678) begin miscompares++;
            $display("FAIL rej_sh_side_effect got %h/%h want 00008001/5678", mem_out, mem[8'h20]); end
        run_access(1'b1, 1'b1, 3'b010, 32'h40, 32'h0);
        vectors++; if (lat !== 1 || err_seen !== 1'b1 || active !== 0) begin miscompares++;
            $display("FAIL rej_rd_and_wr got lat=%0d err=%b act=%0d want 1/1/0",
                     lat, err_seen, active); end
        run_access(1'b1, 1'b0, 3'b011, 32'h40, 32'h0);
        vectors++; if (lat !== 1 || err_seen !== 1'b1 || active !== 0) begin miscompares++;
            $display("FAIL rej_len011 got lat=%0d err=%b act=%0d want 1/1/0",
                     lat, err_seen, active); end
        run_access(1'b0, 1'b1, 3'b100, 32'h40, 32'h0);
        vectors++; if (lat !== 1 || err_seen !== 1'b1) begin miscompares++;
            $display("FAIL rej_store_len100 got lat=%0d err=%b want 1/1", lat, err_seen); end
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        vectors++; if (lat !== 5 || err_seen !== 1'b0) begin miscompares++;
            $display("FAIL ok_after_reject got lat=%0d err=%b want 5/0", lat, err_seen); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_reset_mid();
        test_back_to_back();
        test_byte();
        test_half();
        test_reject();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
